loa_lock_result_checker: RTL and testbench



---
 rtl/loa_check_pkg.sv | 33 +++
 rtl/loa_lock_result_checker_if.sv | 19 +
 rtl/loa_popcount.sv | 15 +
 rtl/loa_lock_result_checker.sv | 181 ++++++++++++++++++
 tb/tb_loa_lock_result_checker.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/loa_check_pkg.sv
// Shared types and the golden lower-part-OR adder model for the locked-adder
// result checker.
//   state_t    : checker FSM states (IDLE, RUN, DRAIN, REPORT)
//   WIDTH_DEF / LOWER_WIDTH_DEF : default operand width and OR-part width
//   loa_golden : reference LOA sum; operands and result are carried at
//                MAX_WIDTH so one function serves every WIDTH/LOWER_WIDTH.
package loa_check_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

   localparam int WIDTH_DEF       = 32;
   localparam int LOWER_WIDTH_DEF = 8;
   localparam int MAX_WIDTH       = 64;

   typedef logic [MAX_WIDTH:0] wide_t;

   // Low lw bits are a|b; the upper part is a true add with a carry-in taken
   // from the AND of the top OR-part bits. The carry-out lands in bit w.
   function automatic wide_t loa_golden(input logic [MAX_WIDTH-1:0] a,
                                        input logic [MAX_WIDTH-1:0] b,
                                        input int w,
                                        input int lw);
      wide_t wa, wb, w_mask, lo_mask, hi, cin_v;
      w_mask  = (wide_t'(1) << w) - wide_t'(1);
      lo_mask = (wide_t'(1) << lw) - wide_t'(1);
      wa      = wide_t'(a) & w_mask;
      wb      = wide_t'(b) & w_mask;
      cin_v   = ((wa & wb) >> (lw - 1)) & wide_t'(1);
      hi      = ((wa >> lw) + (wb >> lw) + cin_v) << lw;
      return hi | ((wa | wb) & lo_mask);
   endfunction

endpackage

// File: rtl/loa_lock_result_checker_if.sv
// Sample stream from the locked adder into the checker.
//   in_valid / in_ready : handshake, transfer when both are high
//   add1_i, add2_i      : operands applied to the locked adder (WIDTH)
//   result_o            : locked adder output for that pair (WIDTH+1)
// master drives the sample, slave (the checker) drives in_ready.
interface loa_lock_result_checker_if
   import loa_check_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] add1_i;
   logic [WIDTH-1:0] add2_i;
   logic [WIDTH:0]   result_o;

   modport master (output in_valid, add1_i, add2_i, result_o, input in_ready);
   modport slave  (input in_valid, add1_i, add2_i, result_o, output in_ready);
endinterface

// File: rtl/loa_popcount.sv
// Combinational population count.
//   d   : input vector (N bits)
//   cnt : number of ones in d (CW bits)
module loa_popcount #(
   parameter int N  = 33,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  d,
   output logic [CW-1:0] cnt
);
   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) cnt = cnt + CW'(d[i]);
   end
endmodule

// File: rtl/loa_lock_result_checker.sv
// Checks a locked LOA adder's output against the golden LOA result and
// accumulates mismatch / bit-error statistics over a window of samples.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : opens a window (honoured in IDLE and REPORT only)
//   window_len   : samples per window, latched on start, 0 means 1
//   bus          : sample stream (slave side: in_valid, in_ready, add1_i,
//                  add2_i, result_o)
//   busy         : window in progress (RUN or DRAIN)
//   done         : one-cycle pulse once the window's statistics are final
//   sample_cnt   : samples accepted this window (saturating)
//   mismatch_cnt : samples whose result differed from golden (saturating)
//   bit_err_cnt  : summed Hamming distance to golden (saturating)
// Optional macro LOA_CHECK_FIRST_FAIL_EN adds first_fail_valid/_a/_b/_res,
// capturing the first mismatching sample of the window.
module loa_lock_result_checker
   import loa_check_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int LOWER_WIDTH = LOWER_WIDTH_DEF,
   parameter int CNT_WIDTH   = 16,
   parameter int ERR_WIDTH   = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] window_len,
   loa_lock_result_checker_if.slave bus,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] sample_cnt,
   output logic [CNT_WIDTH-1:0] mismatch_cnt,
   output logic [ERR_WIDTH-1:0] bit_err_cnt
`ifdef LOA_CHECK_FIRST_FAIL_EN
   ,
   output logic                 first_fail_valid,
   output logic [WIDTH-1:0]     first_fail_a,
   output logic [WIDTH-1:0]     first_fail_b,
   output logic [WIDTH:0]       first_fail_res
`endif
);
   localparam int STAGES = 2;
   localparam int POP_W  = $clog2(WIDTH + 2);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               state;
   logic                 ready;
   logic [CNT_WIDTH-1:0] win_len;
   logic [CNT_WIDTH-1:0] acc_cnt;
   logic [STAGES:1]      vld_pipe;
   logic                 accept;
   logic                 last_acc;

   logic [WIDTH:0]       g;
   logic [WIDTH:0]       s1_g, s1_res, s1_diff;
   logic [POP_W-1:0]     s1_pop, s2_pop;
   logic                 s2_mis;
   logic [ERR_WIDTH:0]   err_sum;
   logic [ERR_WIDTH-1:0] err_sat;
`ifdef LOA_CHECK_FIRST_FAIL_EN
   logic [WIDTH-1:0]     s1_a, s1_b, s2_a, s2_b;
   logic [WIDTH:0]       s2_res;
`endif

   assign bus.in_ready = ready;
   assign accept       = bus.in_valid & ready;
   // acc_cnt never exceeds win_len, so equality with win_len-1 marks the last.
   assign last_acc     = (acc_cnt == win_len - CNT_WIDTH'(1));

   assign g = (WIDTH + 1)'(loa_golden(MAX_WIDTH'(bus.add1_i), MAX_WIDTH'(bus.add2_i),
                                      WIDTH, LOWER_WIDTH));

   // ---- datapath: S1 golden/result, S2 mismatch flag and popcount ----
   assign s1_diff = s1_g ^ s1_res;

   loa_popcount #(.N(WIDTH + 1), .CW(POP_W)) u_pop (.d(s1_diff), .cnt(s1_pop));

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_g   <= g;
         s1_res <= bus.result_o;
`ifdef LOA_CHECK_FIRST_FAIL_EN
         s1_a   <= bus.add1_i;
         s1_b   <= bus.add2_i;
`endif
      end
      s2_mis <= |s1_diff;
      s2_pop <= s1_pop;
`ifdef LOA_CHECK_FIRST_FAIL_EN
      s2_a   <= s1_a;
      s2_b   <= s1_b;
      s2_res <= s1_res;
`endif
   end

   // Widen by one bit so an overflow is visible and can clamp to all-ones.
   assign err_sum = {1'b0, bit_err_cnt} + (ERR_WIDTH + 1)'(s2_pop);
   assign err_sat = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];

   // ---- control and statistics ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ready        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         win_len      <= '0;
         acc_cnt      <= '0;
         vld_pipe     <= '0;
         sample_cnt   <= '0;
         mismatch_cnt <= '0;
         bit_err_cnt  <= '0;
`ifdef LOA_CHECK_FIRST_FAIL_EN
         first_fail_valid <= 1'b0;
         first_fail_a     <= '0;
         first_fail_b     <= '0;
         first_fail_res   <= '0;
`endif
      end else begin
         done     <= 1'b0;
         vld_pipe <= {vld_pipe[STAGES-1:1], accept};

         if (accept) begin
            acc_cnt <= acc_cnt + CNT_WIDTH'(1);
            if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + CNT_WIDTH'(1);
         end

         // S2 retirement
         if (vld_pipe[STAGES]) begin
            if (s2_mis && mismatch_cnt != CNT_MAX)
               mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(1);
            bit_err_cnt <= err_sat;
`ifdef LOA_CHECK_FIRST_FAIL_EN
            if (s2_mis && !first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_a     <= s2_a;
               first_fail_b     <= s2_b;
               first_fail_res   <= s2_res;
            end
`endif
         end

         case (state)
            IDLE, REPORT: begin
               // Pipeline is empty here, so clearing cannot race a retirement.
               if (start) begin
                  state        <= RUN;
                  ready        <= 1'b1;
                  busy         <= 1'b1;
                  win_len      <= (window_len == '0) ? CNT_WIDTH'(1) : window_len;
                  acc_cnt      <= '0;
                  sample_cnt   <= '0;
                  mismatch_cnt <= '0;
                  bit_err_cnt  <= '0;
`ifdef LOA_CHECK_FIRST_FAIL_EN
                  first_fail_valid <= 1'b0;
                  first_fail_a     <= '0;
                  first_fail_b     <= '0;
                  first_fail_res   <= '0;
`endif
               end
            end
            RUN: begin
               if (accept && last_acc) begin
                  ready <= 1'b0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Counters took the last retirement on the previous edge.
               if (vld_pipe == '0) begin
                  state <= REPORT;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_loa_lock_result_checker.sv
// Self-checking bench for loa_lock_result_checker: directed windows from the
// test plan plus randomized windows with backpressure, compared against a
// behavioural LOA model and scoreboard counters kept in the bench. A second
// instance with narrow counters exercises saturation.
module tb_loa_lock_result_checker;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] window_len;
   logic        busy, done;
   logic [15:0] sample_cnt, mismatch_cnt;
   logic [23:0] bit_err_cnt;

   logic        start_s;
   logic [3:0]  wl_s;
   logic        busy_s, done_s;
   logic [3:0]  sc_s, mc_s;
   logic [5:0]  be_s;

`ifdef LOA_CHECK_FIRST_FAIL_EN
   logic        ff_v, ff_v_s;
   logic [31:0] ff_a, ff_b, ff_a_s, ff_b_s;
   logic [32:0] ff_r, ff_r_s;
`endif

   int checks = 0;
   int errors = 0;

   longint qa[$], qb[$], qr[$];

   always #5 clk = ~clk;

   loa_lock_result_checker_if #(.WIDTH(32)) bus ();
   loa_lock_result_checker_if #(.WIDTH(32)) bus_s ();

   loa_lock_result_checker u_dut (
      .clk(clk), .rst(rst), .start(start), .window_len(window_len), .bus(bus),
      .busy(busy), .done(done), .sample_cnt(sample_cnt),
      .mismatch_cnt(mismatch_cnt), .bit_err_cnt(bit_err_cnt)
`ifdef LOA_CHECK_FIRST_FAIL_EN
      , .first_fail_valid(ff_v), .first_fail_a(ff_a), .first_fail_b(ff_b),
      .first_fail_res(ff_r)
`endif
   );

   loa_lock_result_checker #(.CNT_WIDTH(4), .ERR_WIDTH(6)) u_sat (
      .clk(clk), .rst(rst), .start(start_s), .window_len(wl_s), .bus(bus_s),
      .busy(busy_s), .done(done_s), .sample_cnt(sc_s),
      .mismatch_cnt(mc_s), .bit_err_cnt(be_s)
`ifdef LOA_CHECK_FIRST_FAIL_EN
      , .first_fail_valid(ff_v_s), .first_fail_a(ff_a_s), .first_fail_b(ff_b_s),
      .first_fail_res(ff_r_s)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference LOA: OR on the low byte, real add above with carry-in from bit 7.
   function automatic longint golden(input longint a, input longint b);
      longint lo, hi, cin;
      lo  = (a | b) & 64'hFF;
      cin = (a >> 7) & (b >> 7) & 1;
      hi  = (a >> 8) + (b >> 8) + cin;
      return (hi << 8) | lo;
   endfunction

   function automatic longint corrupt(input longint g);
      case ($urandom_range(2, 0))
         0:       return g;
         1:       return g ^ (64'd1 << $urandom_range(32, 0));
         default: return g ^ ({32'd0, $urandom} | (longint'($urandom_range(1, 0)) << 32));
      endcase
   endfunction

   task automatic push(input longint a, input longint b, input longint r);
      qa.push_back(a); qb.push_back(b); qr.push_back(r);
   endtask

   task automatic clear_q();
      qa.delete(); qb.delete(); qr.delete();
   endtask

   // Runs one window over the queued samples. poke issues a start while the
   // checker is draining the last sample; it must have no effect.
   task automatic run_window(input int wl, input bit bubbles, input bit poke);
      int eff, acc, idx, cyc, last_acc, done_n, done_at;
      longint mis, bits, g;
      bit poked, took;
      eff = (wl == 0) ? 1 : wl;
      acc = 0; idx = 0; cyc = 0; last_acc = 0; done_n = 0; done_at = 0;
      mis = 0; bits = 0; poked = 0;
      @(negedge clk);
      start = 1'b1; window_len = 16'(wl);
      @(negedge clk);
      start = 1'b0;
      chk("busy_in_run", busy, 1);
      while (cyc < 400 && !(acc == eff && done_n > 0 && cyc >= done_at + 3)) begin
         chk("in_ready", bus.in_ready, acc < eff);
         start = poke && acc == eff && !poked;
         if (start) begin poked = 1; window_len = 16'd7; end
         if (idx < qa.size()) begin
            bus.in_valid = bubbles ? 1'($urandom_range(1, 0)) : 1'b1;
            bus.add1_i   = 32'(qa[idx]);
            bus.add2_i   = 32'(qb[idx]);
            bus.result_o = 33'(qr[idx]);
         end else begin
            bus.in_valid = 1'b1;
            bus.add1_i   = $urandom;
            bus.add2_i   = $urandom;
            bus.result_o = 33'($urandom);
         end
         took = bus.in_valid && bus.in_ready && idx < qa.size();
         if (took) begin
            g = golden(qa[idx], qb[idx]);
            if (g != qr[idx]) mis++;
            bits += $countones(g ^ qr[idx]);
            idx++; acc++;
         end
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (took) last_acc = cyc;
         if (done) begin done_n++; done_at = cyc; end
      end
      bus.in_valid = 1'b0;
      chk("window_finished", (acc == eff && done_n > 0), 1);
      chk("done_pulses", done_n, 1);
      chk("done_latency", done_at - last_acc, 3);
      chk("sample_cnt", sample_cnt, eff);
      chk("mismatch_cnt", mismatch_cnt, mis);
      chk("bit_err_cnt", bit_err_cnt, bits);
      chk("busy_report", busy, 0);
      chk("ready_report", bus.in_ready, 0);
   endtask

   initial begin
      longint a, b, g;
      bit seen;
      rst = 1'b1; start = 1'b0; window_len = '0;
      start_s = 1'b0; wl_s = '0;
      bus.in_valid = 1'b0; bus.add1_i = '0; bus.add2_i = '0; bus.result_o = '0;
      bus_s.in_valid = 1'b0; bus_s.add1_i = '0; bus_s.add2_i = '0; bus_s.result_o = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_counts", {sample_cnt, mismatch_cnt, bit_err_cnt}, 0);
      rst = 1'b0;
      @(negedge clk);

      // correct results
      clear_q();
      push(0, 0, 0);
      push(64'h5555_5555, 64'hAAAA_AAAA, 64'h0_FFFF_FFFF);
      push(64'h0000_0001, 64'hDEAF_BEEF, 64'h0_DEAF_BEEF);
      push(64'h8051_9860, 64'h8086_BA3E, 64'h1_00D8_527E);
      run_window(4, 0, 0);
      chk("clean_mismatch", mismatch_cnt, 0);

      // corrupted results
      clear_q();
      push(64'h5555_5555, 64'hAAAA_AAAA, 64'h0_FFFF_FF00);
      push(0, 0, 64'h1_0000_0000);
      run_window(2, 0, 0);
      chk("corrupt_mismatch", mismatch_cnt, 2);
      chk("corrupt_biterr", bit_err_cnt, 9);

`ifdef LOA_CHECK_FIRST_FAIL_EN
      clear_q();
      push(64'h1234_5678, 64'h0F0F_0F0F, golden(64'h1234_5678, 64'h0F0F_0F0F));
      push(64'hFFFF_FFFF, 64'h0000_0080, golden(64'hFFFF_FFFF, 64'h0000_0080));
      push(64'h1111_4477, 64'hEEAA_0000, 64'h0_FFBB_4467);
      push(64'h2222_2222, 64'h3333_3333, 64'h1_0000_0000);
      run_window(4, 0, 0);
      chk("ff_valid", ff_v, 1);
      chk("ff_a", ff_a, 64'h1111_4477);
      chk("ff_b", ff_b, 64'hEEAA_0000);
      chk("ff_res", ff_r, 64'h0_FFBB_4467);
      repeat (4) @(negedge clk);
      chk("ff_hold", {ff_v, ff_a}, {1'b1, 32'h1111_4477});
`endif

      // randomized backpressure, then a few random windows back to back
      for (int w = 0; w < 4; w++) begin
         int wl;
         wl = (w == 0) ? 16 : $urandom_range(20, 1);
         clear_q();
         for (int i = 0; i < wl + 2; i++) begin
            a = $urandom; b = $urandom;
            push(a, b, corrupt(golden(a, b)));
         end
         run_window(wl, 1, 0);
      end

      // window_len of zero behaves as one
      clear_q();
      push(64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
      push(1, 1, 0);
      push(2, 2, 0);
      run_window(0, 1, 0);

      // start during DRAIN is ignored
      clear_q();
      push(64'h0000_00FF, 64'h0000_0080, 64'h0_0000_0100);
      push(3, 4, 7);
      run_window(1, 0, 1);

      // saturation on the narrow instance: every result fully inverted
      @(negedge clk);
      start_s = 1'b1; wl_s = 4'hF;
      @(negedge clk);
      start_s = 1'b0;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         a = $urandom; b = $urandom; g = golden(a, b);
         bus_s.add1_i   = 32'(a);
         bus_s.add2_i   = 32'(b);
         bus_s.result_o = 33'(g ^ 64'h1_FFFF_FFFF);
         bus_s.in_valid = 1'b1;
         @(negedge clk);
         if (done_s) seen = 1;
      end
      repeat (3) @(negedge clk);
      bus_s.in_valid = 1'b0;
      chk("sat_done", seen, 1);
      chk("sat_samples", sc_s, 4'hF);
      chk("sat_mismatch", mc_s, 4'hF);
      chk("sat_biterr", be_s, 6'h3F);

      // reset mid-window aborts at once with no done pulse
      @(negedge clk);
      start = 1'b1; window_len = 16'd10;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = $urandom; b = $urandom;
         bus.add1_i = 32'(a); bus.add2_i = 32'(b);
         bus.result_o = 33'(golden(a, b) ^ 64'd1);
         bus.in_valid = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("mid_samples", sample_cnt, 5);
      chk("mid_mismatch", mismatch_cnt, 3);
      chk("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_ready", bus.in_ready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_counts", {sample_cnt, mismatch_cnt, bit_err_cnt}, 0);
`ifdef LOA_CHECK_FIRST_FAIL_EN
      chk("arst_ff", ff_v, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      chk("no_done_after_abort", seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
